// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the pipeline hazard scoreboard
package hazard_pkg;

    // Widest register address any configuration may use; narrower REG_AW
    // values are zero-extended into the entry fields.
    localparam int MAX_AW = 8;

    // Forwarding select meaning "take the operand from the register file".
    localparam int FWD_NONE = 0;

    typedef struct packed {
        logic              valid;
        logic [MAX_AW-1:0] rd;
        logic              wr;
        logic              is_load;
        logic [MAX_AW-1:0] rs1;
        logic [MAX_AW-1:0] rs2;
        logic              rs1_used;
        logic              rs2_used;
    } sb_entry_t;

    // Stage k's result is selected with code k-1 (stage 1 never forwards to itself).
    function automatic int stage_to_sel(input int k);
        return k - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clock  rising-edge clock
//   clear  synchronous clear, wins over inc
//   inc    count one event this cycle
//   count  current value, holds at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use stall, forwarding select and flush control for the in-order pipeline
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-low reset
//   dec_*                    instruction currently in decode
//   flush                    taken branch resolved in stage 1; kills decode and fetch
//   stall                    hold fetch and decode this cycle (combinational)
//   stage_valid              bit k-1 set when stage k holds a real instruction
//   fwd_sel_a / fwd_sel_b    stage-1 operand source: 0 = register file, j = stage j+1
//   stall_cnt / flush_cnt    saturating event counters
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NUM_STAGES     = 3,
    parameter  int REG_AW         = 5,
    parameter  int LOAD_FWD_STAGE = 3,
    parameter  int CNT_W          = 32,
    localparam int SEL_W          = $clog2(NUM_STAGES)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic [REG_AW-1:0]     dec_rs1,
    input  logic                  dec_rs1_used,
    input  logic [REG_AW-1:0]     dec_rs2,
    input  logic                  dec_rs2_used,
    input  logic [REG_AW-1:0]     dec_rd,
    input  logic                  dec_wr_en,
    input  logic                  dec_is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // sb[k] is the instruction in stage k (1 = execute ... NUM_STAGES = writeback).
    sb_entry_t sb [1:NUM_STAGES];
    sb_entry_t dec_entry;

    logic [MAX_AW-1:0] rs1_x;
    logic [MAX_AW-1:0] rs2_x;
    logic              raw_hazard;

    // x0 writes are architecturally void, so they never produce a value.
    function automatic logic is_producer(input sb_entry_t e);
        return e.valid & e.wr & (e.rd != '0);
    endfunction

    assign rs1_x = MAX_AW'(dec_rs1);
    assign rs2_x = MAX_AW'(dec_rs2);

    // A load is only hazardous while it is too young to reach its forwarding
    // point by the time the consumer sits in stage 1.
    always_comb begin
        raw_hazard = 1'b0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            if ((k <= LOAD_FWD_STAGE - 2) && is_producer(sb[k]) && sb[k].is_load) begin
                if ((dec_rs1_used && (sb[k].rd == rs1_x)) ||
                    (dec_rs2_used && (sb[k].rd == rs2_x))) begin
                    raw_hazard = 1'b1;
                end
            end
        end
    end

    assign stall = dec_valid & raw_hazard & ~flush;

    always_comb begin
        dec_entry = '0;
        dec_entry.valid = dec_valid & ~stall & ~flush;
        if (dec_entry.valid) begin
            dec_entry.rd       = MAX_AW'(dec_rd);
            dec_entry.wr       = dec_wr_en;
            dec_entry.is_load  = dec_is_load;
            dec_entry.rs1      = rs1_x;
            dec_entry.rs2      = rs2_x;
            dec_entry.rs1_used = dec_rs1_used;
            dec_entry.rs2_used = dec_rs2_used;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                sb[k] <= '0;
            end
        end else begin
            sb[1] <= dec_entry;
            for (int k = 2; k <= NUM_STAGES; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            stage_valid[k-1] = sb[k].valid;
        end
    end

    // Scan oldest to youngest so the nearest matching producer is written last.
    always_comb begin
        fwd_sel_a = SEL_W'(FWD_NONE);
        fwd_sel_b = SEL_W'(FWD_NONE);
        for (int k = NUM_STAGES; k >= 2; k--) begin
            if (sb[1].valid && is_producer(sb[k])) begin
                if (sb[1].rs1_used && (sb[k].rd == sb[1].rs1)) begin
                    fwd_sel_a = SEL_W'(stage_to_sel(k));
                end
                if (sb[1].rs2_used && (sb[k].rd == sb[1].rs2)) begin
                    fwd_sel_b = SEL_W'(stage_to_sel(k));
                end
            end
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clock (clock),
        .clear (~reset),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clock (clock),
        .clear (~reset),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard (default and deep configurations)
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_rs1;
    logic       dec_rs1_used;
    logic [4:0] dec_rs2;
    logic       dec_rs2_used;
    logic [4:0] dec_rd;
    logic       dec_wr_en;
    logic       dec_is_load;
    logic       flush;

    logic        stall;
    logic [2:0]  stage_valid;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic        stall6;
    logic [4:0]  stage_valid6;
    logic [2:0]  fwd_sel_a6;
    logic [2:0]  fwd_sel_b6;
    logic [1:0]  stall_cnt6;
    logic [1:0]  flush_cnt6;

    always #5 clock = ~clock;

    hazard_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2      (dec_rs2),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_wr_en    (dec_wr_en),
        .dec_is_load  (dec_is_load),
        .flush        (flush),
        .stall        (stall),
        .stage_valid  (stage_valid),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    hazard_scoreboard #(
        .NUM_STAGES     (5),
        .REG_AW         (5),
        .LOAD_FWD_STAGE (4),
        .CNT_W          (2)
    ) dut6 (
        .clock        (clock),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_rs1      (dec_rs1),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2      (dec_rs2),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd       (dec_rd),
        .dec_wr_en    (dec_wr_en),
        .dec_is_load  (dec_is_load),
        .flush        (flush),
        .stall        (stall6),
        .stage_valid  (stage_valid6),
        .fwd_sel_a    (fwd_sel_a6),
        .fwd_sel_b    (fwd_sel_b6),
        .stall_cnt    (stall_cnt6),
        .flush_cnt    (flush_cnt6)
    );

    typedef struct {
        string      tag;
        bit         which;
        logic       stall;
        logic [7:0] sv;
        logic [7:0] sa;
        logic [7:0] sb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic fl);
        dec_valid    = v;
        dec_rd       = rd;
        dec_wr_en    = wr;
        dec_is_load  = ld;
        dec_rs1      = rs1;
        dec_rs1_used = u1;
        dec_rs2      = rs2;
        dec_rs2_used = u2;
        flush        = fl;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Expected outputs for the cycle just driven; the negedge monitor consumes them.
    task automatic expect_out(input string tag, input bit which, input logic st,
                              input logic [7:0] sv, input logic [7:0] sa, input logic [7:0] sb);
        exp_t e;
        e.tag = tag; e.which = which; e.stall = st; e.sv = sv; e.sa = sa; e.sb = sb;
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (!e.which) begin
                check_eq({e.tag, "_stall"}, 64'(stall), 64'(e.stall));
                check_eq({e.tag, "_sv"},    64'(stage_valid), 64'(e.sv));
                check_eq({e.tag, "_sela"},  64'(fwd_sel_a), 64'(e.sa));
                check_eq({e.tag, "_selb"},  64'(fwd_sel_b), 64'(e.sb));
            end else begin
                check_eq({e.tag, "_stall"}, 64'(stall6), 64'(e.stall));
                check_eq({e.tag, "_sv"},    64'(stage_valid6), 64'(e.sv));
                check_eq({e.tag, "_sela"},  64'(fwd_sel_a6), 64'(e.sa));
                check_eq({e.tag, "_selb"},  64'(fwd_sel_b6), 64'(e.sb));
            end
        end
    end

    initial begin
        reset = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);

        // Reset held for three edges while decode presents a valid instruction
        next_cycle(); expect_out("t1_rst1", 0, 0, 8'b000, 0, 0);
        next_cycle(); expect_out("t1_rst2", 0, 0, 8'b000, 0, 0);
        check_eq("t1_stall_cnt", 64'(stall_cnt), 64'd0);
        check_eq("t1_flush_cnt", 64'(flush_cnt), 64'd0);
        next_cycle(); reset = 1'b1;
        drive(1'b1, 5'd1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("t1_rel", 0, 0, 8'b000, 0, 0);
        next_cycle(); nop(); expect_out("t1_s1", 0, 0, 8'b001, 0, 0);
        next_cycle(); nop(); expect_out("t1_s2", 0, 0, 8'b010, 0, 0);
        next_cycle(); nop(); expect_out("t1_s3", 0, 0, 8'b100, 0, 0);
        next_cycle(); nop(); expect_out("t1_ret", 0, 0, 8'b000, 0, 0);

        // ALU result forwarded from stage 2 to both operands
        next_cycle(); drive(1, 5'd1, 1, 0, 5'd0, 1, 5'd0, 1, 0); expect_out("t2_a0", 0, 0, 8'b000, 0, 0);
        next_cycle(); drive(1, 5'd2, 1, 0, 5'd1, 1, 5'd1, 1, 0); expect_out("t2_a1", 0, 0, 8'b001, 0, 0);
        next_cycle(); nop(); expect_out("t2_a2", 0, 0, 8'b011, 1, 1);
        next_cycle(); nop(); expect_out("t2_a3", 0, 0, 8'b110, 0, 0);
        next_cycle(); nop(); expect_out("t2_a4", 0, 0, 8'b100, 0, 0);
        next_cycle(); nop(); expect_out("t2_a5", 0, 0, 8'b000, 0, 0);

        // Load-use: one stall, then forward from stage 3
        next_cycle(); drive(1, 5'd5, 1, 1, 5'd0, 1, 5'd0, 0, 0); expect_out("t3_b0", 0, 0, 8'b000, 0, 0);
        next_cycle(); drive(1, 5'd6, 1, 0, 5'd5, 1, 5'd0, 1, 0); expect_out("t3_b1", 0, 1, 8'b001, 0, 0);
        next_cycle(); drive(1, 5'd6, 1, 0, 5'd5, 1, 5'd0, 1, 0); expect_out("t3_b2", 0, 0, 8'b010, 0, 0);
        next_cycle(); nop(); expect_out("t3_b3", 0, 0, 8'b101, 2, 0);
        check_eq("t3_stall_cnt", 64'(stall_cnt), 64'd1);
        check_eq("t3_flush_cnt", 64'(flush_cnt), 64'd0);
        next_cycle(); nop(); expect_out("t3_b4", 0, 0, 8'b010, 0, 0);
        next_cycle(); nop(); expect_out("t3_b5", 0, 0, 8'b100, 0, 0);
        next_cycle(); nop(); expect_out("t3_b6", 0, 0, 8'b000, 0, 0);

        // Two x3 producers in flight: nearest wins; unused rs2 never forwards
        next_cycle(); drive(1, 5'd3, 1, 0, 5'd0, 1, 5'd0, 1, 0); expect_out("t4_c0", 0, 0, 8'b000, 0, 0);
        next_cycle(); drive(1, 5'd3, 1, 0, 5'd0, 1, 5'd0, 1, 0); expect_out("t4_c1", 0, 0, 8'b001, 0, 0);
        next_cycle(); drive(1, 5'd4, 1, 0, 5'd3, 1, 5'd3, 0, 0); expect_out("t4_c2", 0, 0, 8'b011, 0, 0);
        next_cycle(); nop(); expect_out("t4_c3", 0, 0, 8'b111, 1, 0);
        next_cycle(); nop(); expect_out("t4_c4", 0, 0, 8'b110, 0, 0);
        next_cycle(); nop(); expect_out("t4_c5", 0, 0, 8'b100, 0, 0);
        next_cycle(); nop(); expect_out("t4_c6", 0, 0, 8'b000, 0, 0);

        // Same shape writing x0: nothing forwards
        next_cycle(); drive(1, 5'd0, 1, 0, 5'd0, 1, 5'd0, 1, 0); expect_out("t4_d0", 0, 0, 8'b000, 0, 0);
        next_cycle(); drive(1, 5'd0, 1, 0, 5'd0, 1, 5'd0, 1, 0); expect_out("t4_d1", 0, 0, 8'b001, 0, 0);
        next_cycle(); drive(1, 5'd4, 1, 0, 5'd0, 1, 5'd0, 1, 0); expect_out("t4_d2", 0, 0, 8'b011, 0, 0);
        next_cycle(); nop(); expect_out("t4_d3", 0, 0, 8'b111, 0, 0);
        next_cycle(); nop(); expect_out("t4_d4", 0, 0, 8'b110, 0, 0);
        next_cycle(); nop(); expect_out("t4_d5", 0, 0, 8'b100, 0, 0);
        next_cycle(); nop(); expect_out("t4_d6", 0, 0, 8'b000, 0, 0);

        // Load-use hazard coinciding with flush
        next_cycle(); drive(1, 5'd5, 1, 1, 5'd0, 1, 5'd0, 0, 0); expect_out("t5_e0", 0, 0, 8'b000, 0, 0);
        next_cycle(); drive(1, 5'd6, 1, 0, 5'd5, 1, 5'd0, 1, 1); expect_out("t5_e1", 0, 0, 8'b001, 0, 0);
        next_cycle(); nop(); expect_out("t5_e2", 0, 0, 8'b010, 0, 0);
        check_eq("t5_flush_cnt", 64'(flush_cnt), 64'd1);
        check_eq("t5_stall_cnt", 64'(stall_cnt), 64'd1);
        next_cycle(); nop(); expect_out("t5_e3", 0, 0, 8'b100, 0, 0);
        next_cycle(); nop(); expect_out("t5_e4", 0, 0, 8'b000, 0, 0);

        // Reset mid-stream discards in-flight entries and clears counters
        next_cycle(); drive(1, 5'd1, 1, 0, 5'd0, 1, 5'd0, 1, 0); expect_out("r_0", 0, 0, 8'b000, 0, 0);
        next_cycle(); drive(1, 5'd2, 1, 0, 5'd0, 1, 5'd0, 1, 0); expect_out("r_1", 0, 0, 8'b001, 0, 0);
        next_cycle(); reset = 1'b0; nop(); expect_out("r_2", 0, 0, 8'b011, 0, 0);
        next_cycle(); reset = 1'b1; nop(); expect_out("r_3", 0, 0, 8'b000, 0, 0);
        check_eq("r_stall_cnt", 64'(stall_cnt), 64'd0);
        check_eq("r_flush_cnt", 64'(flush_cnt), 64'd0);
        check_eq("r_stall_cnt6", 64'(stall_cnt6), 64'd0);
        check_eq("r_flush_cnt6", 64'(flush_cnt6), 64'd0);

        // Deep pipeline: two stall cycles per load-use, 2-bit counter saturates
        next_cycle(); drive(1, 5'd7, 1, 1, 5'd0, 1, 5'd0, 0, 0); expect_out("t6_g0", 1, 0, 8'b00000, 0, 0);
        next_cycle(); drive(1, 5'd8, 1, 0, 5'd7, 1, 5'd0, 1, 0); expect_out("t6_g1", 1, 1, 8'b00001, 0, 0);
        next_cycle(); drive(1, 5'd8, 1, 0, 5'd7, 1, 5'd0, 1, 0); expect_out("t6_g2", 1, 1, 8'b00010, 0, 0);
        next_cycle(); drive(1, 5'd8, 1, 0, 5'd7, 1, 5'd0, 1, 0); expect_out("t6_g3", 1, 0, 8'b00100, 0, 0);
        next_cycle(); nop(); expect_out("t6_g4", 1, 0, 8'b01001, 3, 0);
        check_eq("t6_stall_cnt_2", 64'(stall_cnt6), 64'd2);
        next_cycle(); drive(1, 5'd9, 1, 1, 5'd0, 1, 5'd0, 0, 0); expect_out("t6_g5", 1, 0, 8'b10010, 0, 0);
        next_cycle(); drive(1, 5'd10, 1, 0, 5'd9, 1, 5'd0, 1, 0); expect_out("t6_g6", 1, 1, 8'b00101, 0, 0);
        next_cycle(); drive(1, 5'd10, 1, 0, 5'd9, 1, 5'd0, 1, 0); expect_out("t6_g7", 1, 1, 8'b01010, 0, 0);
        check_eq("t6_stall_cnt_3", 64'(stall_cnt6), 64'd3);
        next_cycle(); drive(1, 5'd10, 1, 0, 5'd9, 1, 5'd0, 1, 0); expect_out("t6_g8", 1, 0, 8'b10100, 0, 0);
        check_eq("t6_stall_cnt_sat", 64'(stall_cnt6), 64'd3);
        next_cycle(); nop(); expect_out("t6_g9", 1, 0, 8'b01001, 3, 0);
        check_eq("t6_stall_cnt_hold", 64'(stall_cnt6), 64'd3);
        check_eq("t6_flush_cnt", 64'(flush_cnt6), 64'd0);

        next_cycle();
        next_cycle();
        check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
